// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and an iterative
// shift-add multiplier that stalls upstream, feeding the EX/MEM register.
module ex_stage #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch_i,
    input  logic        ALUSrc1_i,
    input  logic        ALUSrc2_i,
    input  logic        RegWr_i,
    input  logic        MemRead_i,
    input  logic        MemWr_i,
    input  logic        loadbyte_i,
    input  logic [1:0]  RegDst_i,
    input  logic [4:0]  ALUOp_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic [31:0] PC_i,
    input  logic [4:0]  shamt_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] extimm_i,
    input  logic        wb_RegWr_i,
    input  logic [4:0]  wb_wa_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic        br_taken_o,
    output logic [31:0] br_target_o,
    output logic        RegWr_o,
    output logic        MemRead_o,
    output logic        MemWr_o,
    output logic        loadbyte_o,
    output logic [1:0]  MemtoReg_o,
    output logic [4:0]  wa_o,
    output logic [31:0] alu_o,
    output logic [31:0] sdata_o,
    output logic [31:0] PC4_o
);

    localparam int unsigned CNT_W  = 6;
    localparam logic [4:0]  OP_SUB = 5'd1;
    localparam logic [4:0]  OP_MUL = 5'd12;
    localparam logic [4:0]  OP_BNE = 5'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        mcand_q;
    logic [31:0]        mplier_q;
    logic [31:0]        acc_q;

    logic [31:0]        fwd_a;
    logic [31:0]        fwd_b;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        alu_res;
    logic [4:0]         wa_sel;
    logic [31:0]        pc4;

    // Operand forwarding: EX/MEM wins over MEM/WB, register 0 is never forwarded
    always_comb begin
        fwd_a = reg1_i;
        if (RegWr_o && (wa_o != 5'd0) && (wa_o == rs_i))
            fwd_a = alu_o;
        else if (wb_RegWr_i && (wb_wa_i != 5'd0) && (wb_wa_i == rs_i))
            fwd_a = wb_data_i;

        fwd_b = reg2_i;
        if (RegWr_o && (wa_o != 5'd0) && (wa_o == rt_i))
            fwd_b = alu_o;
        else if (wb_RegWr_i && (wb_wa_i != 5'd0) && (wb_wa_i == rt_i))
            fwd_b = wb_data_i;
    end

    assign op_a = ALUSrc1_i ? {27'b0, shamt_i} : fwd_a;
    assign op_b = ALUSrc2_i ? extimm_i : fwd_b;
    assign pc4  = PC_i + 32'd4;

    // Single-cycle ALU; MUL is handled by the iterative datapath below
    always_comb begin
        alu_res = 32'd0;
        case (ALUOp_i)
            5'd0:    alu_res = op_a + op_b;
            5'd1:    alu_res = op_a - op_b;
            5'd2:    alu_res = op_a & op_b;
            5'd3:    alu_res = op_a | op_b;
            5'd4:    alu_res = op_a ^ op_b;
            5'd5:    alu_res = ~(op_a | op_b);
            5'd6:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            5'd7:    alu_res = {31'b0, op_a < op_b};
            5'd8:    alu_res = op_b << op_a[4:0];
            5'd9:    alu_res = op_b >> op_a[4:0];
            5'd10:   alu_res = 32'($signed(op_b) >>> op_a[4:0]);
            5'd11:   alu_res = op_b << 16;
            OP_BNE:  alu_res = {31'b0, op_a != op_b};
            default: alu_res = 32'd0;
        endcase
    end

    // Destination register select
    always_comb begin
        case (RegDst_i)
            2'd0:    wa_sel = rt_i;
            2'd1:    wa_sel = rd_i;
            default: wa_sel = 5'd31;
        endcase
    end

    // Stall while a multiply is being started or iterated; released in reset
    assign stall_o = reset & (((state_q == S_IDLE) && (ALUOp_i == OP_MUL)) ||
                              (state_q == S_BUSY));

    // Branch resolution from forwarded operands, suppressed during a stall
    assign br_target_o = pc4 + {extimm_i[29:0], 2'b00};
    assign br_taken_o  = Branch_i & ~stall_o &
                         (((ALUOp_i == OP_SUB) && (fwd_a == fwd_b)) ||
                          ((ALUOp_i == OP_BNE) && (fwd_a != fwd_b)));

    // Multiply FSM, shift-add datapath and EX/MEM register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            RegWr_o    <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWr_o    <= 1'b0;
            loadbyte_o <= 1'b0;
            MemtoReg_o <= 2'd0;
            wa_o       <= 5'd0;
            alu_o      <= 32'd0;
            sdata_o    <= 32'd0;
            PC4_o      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ALUOp_i == OP_MUL) begin
                        mcand_q    <= op_a;
                        mplier_q   <= op_b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        RegWr_o    <= 1'b0;
                        MemRead_o  <= 1'b0;
                        MemWr_o    <= 1'b0;
                        loadbyte_o <= 1'b0;
                        MemtoReg_o <= 2'd0;
                        wa_o       <= 5'd0;
                        alu_o      <= 32'd0;
                        sdata_o    <= 32'd0;
                        PC4_o      <= 32'd0;
                        state_q    <= S_BUSY;
                    end else begin
                        RegWr_o    <= RegWr_i;
                        MemRead_o  <= MemRead_i;
                        MemWr_o    <= MemWr_i;
                        loadbyte_o <= loadbyte_i;
                        MemtoReg_o <= MemtoReg_i;
                        wa_o       <= wa_sel;
                        alu_o      <= alu_res;
                        sdata_o    <= fwd_b;
                        PC4_o      <= pc4;
                    end
                end
                S_BUSY: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1))
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    RegWr_o    <= RegWr_i;
                    MemRead_o  <= MemRead_i;
                    MemWr_o    <= MemWr_i;
                    loadbyte_o <= loadbyte_i;
                    MemtoReg_o <= MemtoReg_i;
                    wa_o       <= wa_sel;
                    alu_o      <= acc_q;
                    sdata_o    <= fwd_b;
                    PC4_o      <= pc4;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized instruction stream
// checked against a behavioural model of the execute stage.
module tb_ex_stage;

    localparam int unsigned MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        Branch_i, ALUSrc1_i, ALUSrc2_i, RegWr_i, MemRead_i, MemWr_i, loadbyte_i;
    logic [1:0]  RegDst_i, MemtoReg_i;
    logic [4:0]  ALUOp_i, shamt_i, rs_i, rt_i, rd_i, wb_wa_i;
    logic [31:0] PC_i, reg1_i, reg2_i, extimm_i, wb_data_i;
    logic        wb_RegWr_i;
    logic        stall_o, br_taken_o, RegWr_o, MemRead_o, MemWr_o, loadbyte_o;
    logic [31:0] br_target_o, alu_o, sdata_o, PC4_o;
    logic [1:0]  MemtoReg_o;
    logic [4:0]  wa_o;

    ex_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .Branch_i(Branch_i), .ALUSrc1_i(ALUSrc1_i), .ALUSrc2_i(ALUSrc2_i),
        .RegWr_i(RegWr_i), .MemRead_i(MemRead_i), .MemWr_i(MemWr_i),
        .loadbyte_i(loadbyte_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
        .MemtoReg_i(MemtoReg_i), .PC_i(PC_i), .shamt_i(shamt_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .extimm_i(extimm_i),
        .wb_RegWr_i(wb_RegWr_i), .wb_wa_i(wb_wa_i), .wb_data_i(wb_data_i),
        .stall_o(stall_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o),
        .RegWr_o(RegWr_o), .MemRead_o(MemRead_o), .MemWr_o(MemWr_o),
        .loadbyte_o(loadbyte_o), .MemtoReg_o(MemtoReg_o), .wa_o(wa_o),
        .alu_o(alu_o), .sdata_o(sdata_o), .PC4_o(PC4_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model of the EX/MEM register contents
    bit          m_regwr, m_memread, m_memwr, m_lb;
    logic [1:0]  m_mtr;
    logic [4:0]  m_wa;
    logic [31:0] m_alu, m_sdata, m_pc4;
    bit          m_pend;      // a multiply is in flight
    int          m_left;      // stalled iteration cycles still to go
    logic [31:0] m_prod;
    bit          last_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_regwr = 0; m_memread = 0; m_memwr = 0; m_lb = 0;
        m_mtr = 0; m_wa = 0; m_alu = 0; m_sdata = 0; m_pc4 = 0;
        m_pend = 0; m_left = 0; m_prod = 0; last_stall = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (m_regwr && m_wa != 0 && m_wa == src) return m_alu;
        if (wb_RegWr_i && wb_wa_i != 0 && wb_wa_i == src) return wb_data_i;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return b << sh;
            9:  return b >> sh;
            10: return 32'($signed(b) >>> sh);
            11: return b * 32'd65536;
            13: return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check combinational outputs, advance model, check registers
    task automatic cycle();
        logic [31:0] a, b, oa, ob;
        bit es, eb;
        #2;
        a  = fwd(rs_i, reg1_i);
        b  = fwd(rt_i, reg2_i);
        oa = ALUSrc1_i ? {27'b0, shamt_i} : a;
        ob = ALUSrc2_i ? extimm_i : b;
        es = m_pend ? (m_left > 0) : (ALUOp_i == 12);
        eb = Branch_i && !es && ((ALUOp_i == 1 && a == b) || (ALUOp_i == 13 && a != b));
        chk("stall", 32'(stall_o), 32'(es));
        chk("br_taken", 32'(br_taken_o), 32'(eb));
        chk("br_target", br_target_o, PC_i + 4 + extimm_i * 4);
        if ((!m_pend && ALUOp_i == 12) || (m_pend && m_left > 0)) begin
            if (!m_pend) begin
                m_pend = 1; m_left = MUL_CYCLES; m_prod = oa * ob;
            end else begin
                m_left--;
            end
            m_regwr = 0; m_memread = 0; m_memwr = 0; m_lb = 0;
            m_mtr = 0; m_wa = 0; m_alu = 0; m_sdata = 0; m_pc4 = 0;
        end else begin
            m_alu     = m_pend ? m_prod : ref_alu(ALUOp_i, oa, ob);
            m_pend    = 0;
            m_regwr   = RegWr_i; m_memread = MemRead_i; m_memwr = MemWr_i; m_lb = loadbyte_i;
            m_mtr     = MemtoReg_i;
            m_wa      = (RegDst_i == 0) ? rt_i : (RegDst_i == 1) ? rd_i : 5'd31;
            m_sdata   = b;
            m_pc4     = PC_i + 4;
        end
        last_stall = es;
        @(posedge clk);
        #1;
        chk("RegWr", 32'(RegWr_o), 32'(m_regwr));
        chk("MemRead", 32'(MemRead_o), 32'(m_memread));
        chk("MemWr", 32'(MemWr_o), 32'(m_memwr));
        chk("loadbyte", 32'(loadbyte_o), 32'(m_lb));
        chk("MemtoReg", 32'(MemtoReg_o), 32'(m_mtr));
        chk("wa", 32'(wa_o), 32'(m_wa));
        chk("alu", alu_o, m_alu);
        chk("sdata", sdata_o, m_sdata);
        chk("PC4", PC4_o, m_pc4);
    endtask

    task automatic clear_inputs();
        Branch_i = 0; ALUSrc1_i = 0; ALUSrc2_i = 0; RegWr_i = 0; MemRead_i = 0;
        MemWr_i = 0; loadbyte_i = 0; RegDst_i = 0; ALUOp_i = 0; MemtoReg_i = 0;
        PC_i = 0; shamt_i = 0; rs_i = 0; rt_i = 0; rd_i = 0;
        reg1_i = 0; reg2_i = 0; extimm_i = 0;
        wb_RegWr_i = 0; wb_wa_i = 0; wb_data_i = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_ctl"}, 32'({RegWr_o, MemRead_o, MemWr_o, loadbyte_o, MemtoReg_o}), 32'd0);
        chk({tag, "_wa"}, 32'(wa_o), 32'd0);
        chk({tag, "_alu"}, alu_o, 32'd0);
        chk({tag, "_sdata"}, sdata_o, 32'd0);
        chk({tag, "_pc4"}, PC4_o, 32'd0);
    endtask

    // Run a multiply already on the inputs; returns stalled cycle count
    task automatic run_mul(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_stall) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        clear_inputs();
        model_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1;

        // Reset asserted in the middle of a multiply
        ALUOp_i = 12; reg1_i = 32'd77; reg2_i = 32'd91;
        for (int i = 0; i < 10; i++) cycle();
        reset = 0;
        #2;
        chk_all_zero("rst_busy");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;

        // ADD 5+7 into r3, then SUB using the forwarded 12
        clear_inputs();
        reg1_i = 5; reg2_i = 7; RegDst_i = 1; rd_i = 3; RegWr_i = 1;
        cycle();
        chk("add_alu", alu_o, 32'd12);
        chk("add_wa", 32'(wa_o), 32'd3);
        chk("add_regwr", 32'(RegWr_o), 32'd1);
        clear_inputs();
        ALUOp_i = 1; rs_i = 3; reg1_i = 0; reg2_i = 2;
        cycle();
        chk("sub_fwd", alu_o, 32'd10);

        // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone, then r0
        clear_inputs();
        reg1_i = 100; RegDst_i = 1; rd_i = 4; RegWr_i = 1;
        cycle();
        clear_inputs();
        rs_i = 4; reg1_i = 999; wb_RegWr_i = 1; wb_wa_i = 4; wb_data_i = 200;
        cycle();
        chk("fwd_exmem", alu_o, 32'd100);
        cycle();
        chk("fwd_memwb", alu_o, 32'd200);
        clear_inputs();
        reg1_i = 7; RegDst_i = 1; rd_i = 0; RegWr_i = 1;
        cycle();
        clear_inputs();
        rs_i = 0; reg1_i = 55; wb_RegWr_i = 1; wb_wa_i = 0; wb_data_i = 200;
        cycle();
        chk("fwd_r0", alu_o, 32'd55);

        // Multiplies
        clear_inputs();
        ALUOp_i = 12; reg1_i = 32'hFFFF_FFFF; reg2_i = 3;
        run_mul(n);
        chk("mul1_stalls", 32'(n), 32'd33);
        chk("mul1_res", alu_o, 32'hFFFF_FFFD);
        clear_inputs();
        ALUOp_i = 12; reg1_i = 1234; reg2_i = 5678; RegWr_i = 1; RegDst_i = 1; rd_i = 9;
        run_mul(n);
        chk("mul2_stalls", 32'(n), 32'd33);
        chk("mul2_res", alu_o, 32'd7006652);
        chk("mul2_wa", 32'(wa_o), 32'd9);

        // Branches
        clear_inputs();
        Branch_i = 1; ALUOp_i = 1; PC_i = 32'h100; extimm_i = 4; reg1_i = 9; reg2_i = 9;
        #1;
        chk("beq_taken", 32'(br_taken_o), 32'd1);
        chk("beq_target", br_target_o, 32'h114);
        cycle();
        ALUOp_i = 13;
        #1;
        chk("bne_eq", 32'(br_taken_o), 32'd0);
        cycle();

        // Shifts and compares
        clear_inputs();
        ALUOp_i = 10; ALUSrc1_i = 1; shamt_i = 4; reg2_i = 32'h8000_0000;
        cycle();
        chk("sra", alu_o, 32'hF800_0000);
        clear_inputs();
        ALUOp_i = 7; reg1_i = 32'hFFFF_FFFF; reg2_i = 1;
        cycle();
        chk("sltu", alu_o, 32'd0);
        ALUOp_i = 6;
        cycle();
        chk("slt", alu_o, 32'd1);
        ALUOp_i = 31;
        cycle();
        chk("op31", alu_o, 32'd0);

        // Randomized instruction stream; inputs held while stalled
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                Branch_i   = 1'($urandom_range(0, 1));
                ALUSrc1_i  = ($urandom_range(0, 3) == 0);
                ALUSrc2_i  = ($urandom_range(0, 3) == 0);
                RegWr_i    = 1'($urandom_range(0, 1));
                MemRead_i  = 1'($urandom_range(0, 1));
                MemWr_i    = 1'($urandom_range(0, 1));
                loadbyte_i = 1'($urandom_range(0, 1));
                RegDst_i   = 2'($urandom_range(0, 3));
                MemtoReg_i = 2'($urandom_range(0, 3));
                ALUOp_i    = 5'($urandom_range(0, 31));
                if (ALUOp_i == 12 && $urandom_range(0, 3) != 0) ALUOp_i = 0;
                PC_i       = $urandom;
                shamt_i    = 5'($urandom_range(0, 31));
                rs_i       = 5'($urandom_range(0, 7));
                rt_i       = 5'($urandom_range(0, 7));
                rd_i       = 5'($urandom_range(0, 7));
                reg1_i     = ($urandom_range(0, 3) == 0) ? reg2_i : $urandom;
                reg2_i     = $urandom;
                extimm_i   = $urandom;
                wb_RegWr_i = 1'($urandom_range(0, 1));
                wb_wa_i    = 5'($urandom_range(0, 7));
                wb_data_i  = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
